// File: rtl/wb_sram.sv
// Byte-addressed Wishbone-pipelined RAM with RISC-V access sizes; ack/err arrive LATENCY cycles after acceptance.
// Stall is held only during reset and the optional post-reset clear; otherwise one request per cycle.
module wb_sram #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 1024,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b0,
    parameter     INIT_FILE      = ""
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [2:0]      i_wb_sel,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_wb_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(DEPTH);
    localparam int TOPW = AW + OFFW;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]      state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] mem [DEPTH];

    logic [1:0]      size;
    logic            uns;
    logic [AW-1:0]   word;
    logic [OFFW-1:0] off;
    logic            legal, aligned, in_range, req_err, accept, store_en, clr_en;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdat, sh, mask, rdata;
    int              nbits;

    assign size       = i_wb_sel[1:0];
    assign uns        = i_wb_sel[2];
    assign word       = i_addr[TOPW-1:OFFW];
    assign off        = i_addr[OFFW-1:0];
    assign in_range   = (i_addr[XLEN-1:TOPW] == '0);
    assign o_wb_stall = i_reset || (state == S_CLEAR);
    assign accept     = i_wb_stb && !o_wb_stall;
    assign req_err    = !(legal && aligned && in_range);
    assign store_en   = accept && i_wb_we && !req_err;
    assign clr_en     = (state == S_CLEAR) && !i_reset;

    // Unsigned variants only exist for loads; doubleword forms only on a 64-bit build.
    always_comb begin
        legal = 1'b0;
        case (i_wb_sel)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !i_wb_we;
            3'b011:                 legal = (XLEN == 64);
            3'b110:                 legal = (XLEN == 64) && !i_wb_we;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        case (size)
            2'd1:    aligned = !i_addr[0];
            2'd2:    aligned = (i_addr[1:0] == 2'b00);
            2'd3:    aligned = (i_addr[2:0] == 3'b000);
            default: aligned = 1'b1;
        endcase
    end

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++)
            be[b] = (b >= int'(off)) && (b < int'(off) + (1 << int'(size)));
        wdat = i_data << {off, 3'b000};
    end

    // Sign bit is the top bit of the access mask, found without a variable index.
    always_comb begin
        sh    = mem[word] >> {off, 3'b000};
        nbits = 8 << int'(size);
        mask  = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        rdata = sh & mask;
        if (!uns && |(sh & (mask ^ (mask >> 1))))
            rdata = rdata | ~mask;
    end

    always_ff @(posedge i_clk) begin
        if (clr_en) begin
            mem[clr_cnt] <= '0;
        end else if (store_en) begin
            for (int b = 0; b < NB; b++)
                if (be[b])
                    mem[word][b*8 +: 8] <= wdat[b*8 +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == AW'(DEPTH - 1))
                state <= S_IDLE;
        end
    end

    logic [LATENCY-1:0] p_vld, p_err;
    logic [XLEN-1:0]    p_dat [LATENCY];

    // Load data is captured at acceptance, so a store on the previous edge is already visible.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            p_vld <= '0;
            p_err <= '0;
            for (int i = 0; i < LATENCY; i++)
                p_dat[i] <= '0;
        end else begin
            p_vld[0] <= accept;
            p_err[0] <= accept && req_err;
            p_dat[0] <= (accept && !req_err && !i_wb_we) ? rdata : '0;
            for (int i = 1; i < LATENCY; i++) begin
                p_vld[i] <= p_vld[i-1];
                p_err[i] <= p_err[i-1];
                p_dat[i] <= p_dat[i-1];
            end
        end
    end

    assign o_wb_ack  = p_vld[LATENCY-1] && !p_err[LATENCY-1];
    assign o_wb_err  = p_vld[LATENCY-1] && p_err[LATENCY-1];
    assign o_wb_data = p_dat[LATENCY-1];

    logic [3:0] outstanding;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            outstanding <= '0;
        else
            outstanding <= outstanding + 4'(accept) - 4'(o_wb_ack || o_wb_err);
    end

    a_ack_err_excl: assert property (@(posedge i_clk) !(o_wb_ack && o_wb_err));
    a_no_orphan:    assert property (@(posedge i_clk) disable iff (i_reset)
                                     (o_wb_ack || o_wb_err) |-> (outstanding != 4'd0));
    a_bounded:      assert property (@(posedge i_clk) disable iff (i_reset)
                                     outstanding <= 4'(LATENCY));

endmodule

// File: tb/tb_wb_sram.sv
// Directed bench: a 1-cycle RAM driven from a vector table, plus a 3-cycle clearing RAM
// exercised with pipelined bursts and reset while loads are in flight.
module tb_wb_sram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3;
    localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6, BADSEL = 3'd7;
    localparam int B_LAT = 3;

    logic        rst_a, stb_a, we_a, stall_a, ack_a, err_a;
    logic [2:0]  sel_a;
    logic [31:0] addr_a, wdat_a, rdat_a;
    logic        rst_b, stb_b, we_b, stall_b, ack_b, err_b;
    logic [2:0]  sel_b;
    logic [31:0] addr_b, wdat_b, rdat_b;

    wb_sram #(.XLEN(32), .DEPTH(1024), .LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_wb_stb(stb_a), .i_wb_we(we_a), .i_wb_sel(sel_a),
        .i_addr(addr_a), .i_data(wdat_a), .o_wb_data(rdat_a), .o_wb_stall(stall_a),
        .o_wb_ack(ack_a), .o_wb_err(err_a));

    wb_sram #(.XLEN(32), .DEPTH(16), .LATENCY(B_LAT), .CLEAR_ON_RESET(1'b1)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_wb_stb(stb_b), .i_wb_we(we_b), .i_wb_sel(sel_b),
        .i_addr(addr_b), .i_data(wdat_b), .o_wb_data(rdat_b), .o_wb_stall(stall_b),
        .o_wb_ack(ack_b), .o_wb_err(err_b));

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acks_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic we, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ack, input logic err, input logic [31:0] dat);
        vecs.push_back('{n, we, sel, addr, wd, ack, err, dat});
    endtask

    // Called at a falling edge; the request is accepted on the next rising edge.
    task automatic op_a(input vec_t v);
        check({v.name, " stall"}, 32'(stall_a), 32'd0);
        stb_a = 1'b1; we_a = v.we; sel_a = v.sel; addr_a = v.addr; wdat_a = v.wdat;
        @(negedge clk);
        stb_a = 1'b0;
        check({v.name, " ack"},  32'(ack_a), 32'(v.ack));
        check({v.name, " err"},  32'(err_a), 32'(v.err));
        check({v.name, " data"}, rdat_a, v.dat);
    endtask

    task automatic stall_count_b(output int n);
        n = 0;
        #1;
        while (stall_b && n < 100) begin
            n++;
            @(negedge clk);
            if (ack_b || err_b) acks_seen++;
            #1;
        end
    endtask

    // Request i goes to word i; completion i is due B_LAT samples after it is driven.
    task automatic burst_b(input string name, input int n, input logic we, input logic [31:0] wbase,
                           input logic [31:0] ebase, input int einc);
        logic        exp_ack;
        logic [31:0] exp_dat;
        for (int c = 0; c <= n + B_LAT; c++) begin
            exp_ack = (c >= B_LAT) && (c - B_LAT < n);
            exp_dat = (exp_ack && !we) ? ebase + 32'((c - B_LAT) * einc) : 32'd0;
            check($sformatf("%s c%0d ack", name, c), 32'(ack_b), 32'(exp_ack));
            check($sformatf("%s c%0d err", name, c), 32'(err_b), 32'd0);
            check($sformatf("%s c%0d data", name, c), rdat_b, exp_dat);
            if (c < n) begin
                check($sformatf("%s c%0d stall", name, c), 32'(stall_b), 32'd0);
                stb_b = 1'b1; we_b = we; sel_b = LW;
                addr_b = 32'(c * 4); wdat_b = wbase + 32'(c);
            end else begin
                stb_b = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_a = 1'b1; stb_a = 1'b0; we_a = 1'b0; sel_a = LW; addr_a = '0; wdat_a = '0;
        rst_b = 1'b1; stb_b = 1'b0; we_b = 1'b0; sel_b = LW; addr_b = '0; wdat_b = '0;

        add("sw_10",       1'b1, LW,     32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        add("lw_10",       1'b0, LW,     32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
        add("lb_13",       1'b0, LB,     32'h13,  32'h0,        1'b1, 1'b0, 32'hFFFFFFDE);
        add("lbu_13",      1'b0, LBU,    32'h13,  32'h0,        1'b1, 1'b0, 32'h000000DE);
        add("lh_12",       1'b0, LH,     32'h12,  32'h0,        1'b1, 1'b0, 32'hFFFFDEAD);
        add("lhu_10",      1'b0, LHU,    32'h10,  32'h0,        1'b1, 1'b0, 32'h0000BEEF);
        add("sb_11",       1'b1, LB,     32'h11,  32'hAAAAAA55, 1'b1, 1'b0, 32'h0);
        add("lw_after_sb", 1'b0, LW,     32'h10,  32'h0,        1'b1, 1'b0, 32'hDEAD55EF);
        add("lb_11_pos",   1'b0, LB,     32'h11,  32'h0,        1'b1, 1'b0, 32'h00000055);
        add("lh_11_mis",   1'b0, LH,     32'h11,  32'h0,        1'b0, 1'b1, 32'h0);
        add("sh_11_mis",   1'b1, LH,     32'h11,  32'h00001234, 1'b0, 1'b1, 32'h0);
        add("lw_unchg",    1'b0, LW,     32'h10,  32'h0,        1'b1, 1'b0, 32'hDEAD55EF);
        add("lw_6_mis",    1'b0, LW,     32'h6,   32'h0,        1'b0, 1'b1, 32'h0);
        add("lw_oor",      1'b0, LW,     32'h1000, 32'h0,       1'b0, 1'b1, 32'h0);
        add("sw_oor",      1'b1, LW,     32'h1000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0);
        add("lw_far_oor",  1'b0, LW,     32'h80000010, 32'h0,   1'b0, 1'b1, 32'h0);
        add("sel_111",     1'b0, BADSEL, 32'h10,  32'h0,        1'b0, 1'b1, 32'h0);
        add("ld_x32",      1'b0, LD,     32'h10,  32'h0,        1'b0, 1'b1, 32'h0);
        add("lwu_x32",     1'b0, LWU,    32'h10,  32'h0,        1'b0, 1'b1, 32'h0);
        add("sd_x32",      1'b1, LD,     32'h10,  32'h12345678, 1'b0, 1'b1, 32'h0);
        add("st_sel100",   1'b1, LBU,    32'h10,  32'h00000077, 1'b0, 1'b1, 32'h0);
        add("lw_unchg2",   1'b0, LW,     32'h10,  32'h0,        1'b1, 1'b0, 32'hDEAD55EF);
        add("sw_last",     1'b1, LW,     32'hFFC, 32'h0BADF00D, 1'b1, 1'b0, 32'h0);
        add("lw_last",     1'b0, LW,     32'hFFC, 32'h0,        1'b1, 1'b0, 32'h0BADF00D);
        add("sw_0c",       1'b1, LW,     32'hC,   32'h0,        1'b1, 1'b0, 32'h0);
        add("sh_0e",       1'b1, LH,     32'hE,   32'hFFFF8001, 1'b1, 1'b0, 32'h0);
        add("lw_0c",       1'b0, LW,     32'hC,   32'h0,        1'b1, 1'b0, 32'h80010000);
        add("lh_0e",       1'b0, LH,     32'hE,   32'h0,        1'b1, 1'b0, 32'hFFFF8001);
        add("lhu_0e",      1'b0, LHU,    32'hE,   32'h0,        1'b1, 1'b0, 32'h00008001);
        add("sw_20",       1'b1, LW,     32'h20,  32'h11223344, 1'b1, 1'b0, 32'h0);
        add("sb_22",       1'b1, LB,     32'h22,  32'h00000099, 1'b1, 1'b0, 32'h0);
        add("lbu_22_raw",  1'b0, LBU,    32'h22,  32'h0,        1'b1, 1'b0, 32'h00000099);
        add("lw_20",       1'b0, LW,     32'h20,  32'h0,        1'b1, 1'b0, 32'h11993344);

        repeat (3) @(negedge clk);
        check("a reset ack",   32'(ack_a),   32'd0);
        check("a reset err",   32'(err_a),   32'd0);
        check("a reset data",  rdat_a,       32'd0);
        check("a reset stall", 32'(stall_a), 32'd1);
        check("b reset stall", 32'(stall_b), 32'd1);
        check("b reset ack",   32'(ack_b),   32'd0);

        rst_a = 1'b0;
        #1;
        check("a stall after reset", 32'(stall_a), 32'd0);
        foreach (vecs[i]) op_a(vecs[i]);

        // A store accepted just before reset must survive it.
        stb_a = 1'b1; we_a = 1'b1; sel_a = LW; addr_a = 32'h40; wdat_a = 32'hCAFEF00D;
        @(negedge clk);
        stb_a = 1'b0; rst_a = 1'b1;
        check("a pre-reset store ack", 32'(ack_a), 32'd1);
        @(negedge clk);
        check("a in-reset ack",   32'(ack_a),   32'd0);
        check("a in-reset stall", 32'(stall_a), 32'd1);
        rst_a = 1'b0;
        #1;
        op_a('{"lw_40_retained", 1'b0, LW, 32'h40, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D});

        rst_b = 1'b0;
        stall_count_b(n);
        check("b clear stall cycles", 32'(n), 32'd16);
        burst_b("b fill", 16, 1'b1, 32'h10000000, 32'h0, 0);
        burst_b("b lw3",  3,  1'b0, 32'h0, 32'h10000000, 1);

        stb_b = 1'b1; we_b = 1'b0; sel_b = LW; addr_b = 32'h0;
        @(negedge clk);
        addr_b = 32'h4;
        @(negedge clk);
        acks_seen = 0;
        if (ack_b || err_b) acks_seen++;
        stb_b = 1'b0; rst_b = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (ack_b || err_b) acks_seen++;
        end
        rst_b = 1'b0;
        stall_count_b(n);
        check("b reclear stall cycles", 32'(n), 32'd16);
        check("b acks for flushed loads", 32'(acks_seen), 32'd0);
        burst_b("b cleared", 16, 1'b0, 32'h0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
